vertex_transform_pipe: RTL and testbench

VERTEX_TRANSFORM_PIPE -- requirements
Module: vertex_transform_pipe

---
 rtl/vertex_transform_pipe.sv | 143 ++++++++++++++
 tb/tb_vertex_transform_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_transform_pipe.sv
// vertex_transform_pipe: 4x4 fixed-point matrix transform of homogeneous
// vertices (x,y,z,1) through a 3-stage valid/ready pipeline.
//   S1 registers the 16 coefficient*coordinate products.
//   S2 registers the 4 row sums.
//   S3 registers the shifted, range-limited results (out_*).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   mtx_we/mtx_addr/mtx_data    coefficient write, row-major index r*4+c
//   in_valid/in_ready/in_x/y/z/in_last      vertex input stream
//   out_valid/out_ready/out_x/y/z/w/out_last result stream
//   busy                        any pipeline stage holds a vertex
//   ovf/ovf_clr                 sticky range overflow flag and its clear
module vertex_transform_pipe #(
  parameter int IN_W      = 14,
  parameter int OUT_W     = 11,
  parameter int FRAC_BITS = 4,
  parameter int SAT_EN    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mtx_we,
  input  logic [3:0]              mtx_addr,
  input  logic signed [IN_W-1:0]  mtx_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_x,
  input  logic signed [IN_W-1:0]  in_y,
  input  logic signed [IN_W-1:0]  in_z,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_x,
  output logic signed [OUT_W-1:0] out_y,
  output logic signed [OUT_W-1:0] out_z,
  output logic signed [OUT_W-1:0] out_w,
  output logic                    out_last,
  output logic                    busy,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int unsigned PROD_W = 2 * IN_W;
  localparam int unsigned ACC_W  = 2 * IN_W + 2;

  // Output range limits held at accumulator width for signed compares.
  localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0]   coef     [16];
  logic signed [IN_W-1:0]   coord    [4];
  logic signed [PROD_W-1:0] prod     [16];
  logic signed [ACC_W-1:0]  sum      [4];
  logic signed [ACC_W-1:0]  row_sum  [4];
  logic signed [ACC_W-1:0]  shifted  [4];
  logic signed [OUT_W-1:0]  lim      [4];
  logic [3:0]               row_ovf;
  logic                     v1, v2, last1, last2;
  logic                     en;
  logic                     ovf_hit;

  // Single advance enable: every stage moves together or holds together.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign busy     = v1 || v2 || out_valid;
  assign ovf_hit  = en && v2 && (|row_ovf);

  // Homogeneous coordinate: the fourth column multiplies by 1.
  always_comb begin
    coord[0] = in_x;
    coord[1] = in_y;
    coord[2] = in_z;
    coord[3] = IN_W'(1);
  end

  // Coefficient file, identity on reset; writes are independent of stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        coef[i] <= (i % 5 == 0) ? IN_W'(1 << FRAC_BITS) : '0;
    end else if (mtx_we) begin
      coef[mtx_addr] <= mtx_data;
    end
  end

  // Row sums of the registered products, widened so nothing overflows.
  always_comb begin
    for (int r = 0; r < 4; r++)
      row_sum[r] = ACC_W'(prod[4*r]) + ACC_W'(prod[4*r+1]) +
                   ACC_W'(prod[4*r+2]) + ACC_W'(prod[4*r+3]);
  end

  // Arithmetic shift (floor) then saturate or wrap to the output width.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      shifted[r] = sum[r] >>> FRAC_BITS;
      row_ovf[r] = (shifted[r] > MAX_V) || (shifted[r] < MIN_V);
      if (SAT_EN != 0 && row_ovf[r])
        lim[r] = shifted[r][ACC_W-1] ? MIN_V[OUT_W-1:0] : MAX_V[OUT_W-1:0];
      else
        lim[r] = shifted[r][OUT_W-1:0];
    end
  end

  // Pipeline registers and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_w     <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < 16; i++) prod[i] <= '0;
      for (int r = 0; r < 4; r++)  sum[r]  <= '0;
    end else begin
      // A new overflow takes priority over a clear on the same edge.
      if (ovf_hit)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (en) begin
        v1    <= in_valid;
        last1 <= in_valid && in_last;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            prod[4*r+c] <= PROD_W'(coef[4*r+c]) * PROD_W'(coord[c]);
        v2    <= v1;
        last2 <= last1;
        for (int r = 0; r < 4; r++) sum[r] <= row_sum[r];
        out_valid <= v2;
        out_last  <= last2;
        out_x     <= lim[0];
        out_y     <= lim[1];
        out_z     <= lim[2];
        out_w     <= lim[3];
      end
    end
  end

endmodule

// File: tb/tb_vertex_transform_pipe.sv
// Testbench for vertex_transform_pipe: directed steps plus randomized traffic,
// scored against an arithmetic model of the matrix transform.
module tb_vertex_transform_pipe;

  localparam int IN_W  = 14;
  localparam int OUT_W = 11;
  localparam int FRAC  = 4;
  localparam int OMAX  = 1023;
  localparam int OMIN  = -1024;

  logic clk = 1'b0;
  logic rst;
  logic mtx_we;
  logic [3:0] mtx_addr;
  logic signed [IN_W-1:0] mtx_data;
  logic in_valid, in_ready, in_last;
  logic signed [IN_W-1:0] in_x, in_y, in_z;
  logic out_valid, out_ready, out_last;
  logic signed [OUT_W-1:0] out_x, out_y, out_z, out_w;
  logic busy, ovf, ovf_clr;

  always #5 clk = ~clk;

  vertex_transform_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_BITS(FRAC), .SAT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .mtx_we(mtx_we), .mtx_addr(mtx_addr), .mtx_data(mtx_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w), .out_last(out_last),
    .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int x, y, z, w;
    bit last;
  } exp_t;

  int   mm [16];
  exp_t q [$];
  int   delivered = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Floor division by 2^FRAC, written as plain integer arithmetic.
  function automatic longint floor_div(input longint a);
    longint d, qv;
    d  = longint'(1) << FRAC;
    qv = a / d;
    if ((a % d) != 0 && a < 0) qv = qv - 1;
    return qv;
  endfunction

  function automatic int clamp(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return int'(v);
  endfunction

  function automatic exp_t model(input int x, input int y, input int z, input bit last);
    exp_t e;
    int res [4];
    for (int r = 0; r < 4; r++)
      res[r] = clamp(floor_div(longint'(mm[4*r]) * x + longint'(mm[4*r+1]) * y +
                               longint'(mm[4*r+2]) * z + longint'(mm[4*r+3])));
    e.x = res[0]; e.y = res[1]; e.z = res[2]; e.w = res[3];
    e.last = last;
    return e;
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  logic signed [OUT_W-1:0] hx, hy, hz, hw;
  logic hl;
  bit holding = 0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      holding = 0;
      for (int i = 0; i < 16; i++) mm[i] = (i % 5 == 0) ? (1 << FRAC) : 0;
    end else begin
      if (in_valid && in_ready)
        q.push_back(model(int'(in_x), int'(in_y), int'(in_z), in_last));
      if (mtx_we) mm[mtx_addr] = int'(mtx_data);
      if (holding) begin
        check("hold_valid", out_valid, 1);
        check("hold_x", out_x, hx);
        check("hold_y", out_y, hy);
        check("hold_z", out_z, hz);
        check("hold_w", out_w, hw);
        check("hold_last", out_last, hl);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_x", out_x, e.x);
          check("sb_y", out_y, e.y);
          check("sb_z", out_z, e.z);
          check("sb_w", out_w, e.w);
          check("sb_last", out_last, e.last);
          delivered++;
        end
      end
      holding = out_valid && !out_ready;
      hx = out_x; hy = out_y; hz = out_z; hw = out_w; hl = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    mtx_we   = 1'b1;
    mtx_addr = 4'(a);
    mtx_data = IN_W'(d);
    tick();
    mtx_we   = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int z, input bit last);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    in_x = IN_W'(x); in_y = IN_W'(y); in_z = IN_W'(z); in_last = last;
    for (int n = 0; n < 50; n++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    for (int n = 0; n < 20; n++) begin
      if (out_valid) return;
      tick();
    end
    check("wait_out_timeout", out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  int vx [6], vy [6], vz [6];
  int idx, base_del;
  bit acc;

  initial begin
    rst = 1'b1; mtx_we = 1'b0; mtx_addr = '0; mtx_data = '0;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_last = 1'b0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;
    check("post_rst_in_ready", in_ready, 1);

    // Identity transform and exact latency.
    in_valid = 1'b1; in_x = 14'sd5; in_y = -14'sd3; in_z = 14'sd7; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    check("lat_c1", out_valid, 0);
    tick();
    check("lat_c2", out_valid, 0);
    tick();
    check("lat_c3", out_valid, 1);
    check("id_x", out_x, 5);
    check("id_y", out_y, -3);
    check("id_z", out_z, 7);
    check("id_w", out_w, 1);
    check("id_ovf", ovf, 0);
    tick();

    // Coefficient write on the accept edge uses the old coefficient.
    mtx_we = 1'b1; mtx_addr = 4'd0; mtx_data = 14'sd5;
    in_valid = 1'b1; in_x = 14'sd16; in_y = 14'sd16; in_z = 14'sd16;
    tick();
    mtx_we = 1'b0; in_valid = 1'b0;
    wait_out();
    check("same_edge_old_coef", out_x, 16);
    wr(1, -3); wr(2, -5); wr(3, 0);
    send(16, 16, 16, 0);
    wait_out();
    check("row0_loaded_x", out_x, -3);
    check("row1_untouched_y", out_y, 16);

    // Saturation and sticky overflow.
    wr(0, 16); wr(1, 0); wr(2, 0);
    send(8191, 0, 0, 0);
    wait_out();
    check("sat_pos_x", out_x, 1023);
    check("sat_pos_ovf", ovf, 1);
    send(-8192, 0, 0, 0);
    wait_out();
    check("sat_neg_x", out_x, -1024);
    send(3, 0, 0, 0);
    wait_out();
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);
    ovf_clr = 1'b1;
    send(8191, 0, 0, 0);
    wait_out();
    check("ovf_set_beats_clr", ovf, 1);
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr_after", ovf, 0);

    // Floor rounding of negative values.
    wr(0, 1);
    send(-1, 0, 0, 0);
    wait_out();
    check("floor_neg1", out_x, -1);
    send(15, 0, 0, 0);
    wait_out();
    check("floor_15", out_x, 0);

    // Random matrix for the remaining traffic.
    for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(0, 64)) - 32);

    // Backpressure: six vertices, output stalled for five cycles.
    for (int i = 0; i < 6; i++) begin
      vx[i] = int'($urandom_range(0, 1000)) - 500;
      vy[i] = int'($urandom_range(0, 1000)) - 500;
      vz[i] = int'($urandom_range(0, 1000)) - 500;
    end
    idx = 0;
    base_del = delivered;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc >= 5);
      if (idx < 6) begin
        in_valid = 1'b1;
        in_x = IN_W'(vx[idx]); in_y = IN_W'(vy[idx]); in_z = IN_W'(vz[idx]);
        in_last = (idx == 5);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (cyc == 4) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_held_count", idx, 3);
        check("bp_busy", busy, 1);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    check("bp_all_accepted", idx, 6);
    check("bp_all_delivered", delivered - base_del, 6);

    // Randomized traffic with matrix writes at arbitrary times.
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = IN_W'($urandom);
      in_y      = IN_W'($urandom);
      in_z      = IN_W'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mtx_we    = ($urandom_range(0, 7) == 0);
      mtx_addr  = 4'($urandom_range(0, 15));
      mtx_data  = IN_W'(int'($urandom_range(0, 80)) - 40);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; mtx_we = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("rand_drained", q.size(), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Reset with three vertices in flight.
    wr(0, 32); wr(1, 0); wr(2, 0); wr(3, 0);
    out_ready = 1'b0;
    send(8191, 0, 0, 0);
    send(1, 2, 3, 0);
    send(4, 5, 6, 1);
    check("mid_busy", busy, 1);
    check("mid_ovf", ovf, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_in_ready", in_ready, 1);
    send(5, -3, 7, 1);
    wait_out();
    check("mid_id_x", out_x, 5);
    check("mid_id_y", out_y, -3);
    check("mid_id_z", out_z, 7);
    check("mid_id_w", out_w, 1);
    check("mid_id_last", out_last, 1);
    repeat (6) tick();
    check("final_drained", q.size(), 0);
    check("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
